// File: rtl/arm_mem_pkg.sv
// Shared types and widths for the ARM memory responder.
package arm_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_INST = 2'd1,
    BUSY_DATA = 2'd2
  } state_t;

  // Encoding of the last_grant flag.
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/arm_mem_array.sv
// Single-port word RAM: synchronous write, combinational read on the same address.
// No reset: contents persist across responder resets.
module arm_mem_array
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata_c
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata_c = mem[addr];

endmodule

// File: rtl/arm_mem_responder.sv
// Memory responder for an ARM-style core: arbitrates instruction fetch and data
// ports onto one word RAM, one access in flight, fixed LATENCY to the ack pulse.
module arm_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [WORD_W-1:0] inst_addr,
  output logic [WORD_W-1:0] inst,
  output logic              inst_ack,
  input  logic              mem_req,
  input  logic              mem_write_en,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data_in,
  output logic [WORD_W-1:0] mem_data_out,
  output logic              mem_ack,
  output logic              mem_err
);

  localparam int unsigned    IDX_W     = DEPTH_LOG2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);
  localparam bit             ONE_CYCLE = (LATENCY == 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             cur_write;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;

  logic              grant_inst_c;
  logic              grant_data_c;
  logic              accept_c;
  logic [WORD_W-1:0] acc_addr_c;
  logic              acc_oob_c;
  logic              ram_we_c;
  logic [IDX_W-1:0]  ram_idx_c;
  logic [WORD_W-1:0] ram_rdata_c;
  logic              complete_c;
  logic              done_is_data_c;
  logic              done_write_c;
  logic              done_err_c;

  // Arbitration, RAM port steering and completion decode
  always_comb begin
    grant_inst_c   = 1'b0;
    grant_data_c   = 1'b0;
    complete_c     = 1'b0;
    done_is_data_c = 1'b0;
    done_write_c   = 1'b0;
    done_err_c     = 1'b0;

    if (state == IDLE) begin
      if (inst_req && mem_req) begin
        if (last_grant == GRANT_DATA) begin
          grant_inst_c = 1'b1;
        end else begin
          grant_data_c = 1'b1;
        end
      end else begin
        grant_inst_c = inst_req;
        grant_data_c = mem_req;
      end
    end

    accept_c   = grant_inst_c | grant_data_c;
    acc_addr_c = grant_data_c ? mem_addr : inst_addr;
    acc_oob_c  = (acc_addr_c >> (DEPTH_LOG2 + 2)) != '0;

    // Stores write at acceptance; reads happen at the completion edge using the
    // index captured at acceptance (live index when both edges coincide).
    ram_we_c  = grant_data_c & mem_write_en & ~acc_oob_c;
    ram_idx_c = accept_c ? acc_addr_c[DEPTH_LOG2+1:2] : cur_idx;

    if (accept_c && ONE_CYCLE) begin
      complete_c     = 1'b1;
      done_is_data_c = grant_data_c;
      done_write_c   = grant_data_c & mem_write_en;
      done_err_c     = acc_oob_c;
    end else if ((state != IDLE) && !inst_ack && !mem_ack && (cnt == LAST_CNT)) begin
      complete_c     = 1'b1;
      done_is_data_c = (state == BUSY_DATA);
      done_write_c   = cur_write;
      done_err_c     = cur_err;
    end
  end

  // FSM, latency counter and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_grant   <= GRANT_DATA;
      cur_write    <= 1'b0;
      cur_err      <= 1'b0;
      cur_idx      <= '0;
      inst_ack     <= 1'b0;
      mem_ack      <= 1'b0;
      mem_err      <= 1'b0;
      inst         <= '0;
      mem_data_out <= '0;
    end else begin
      inst_ack     <= 1'b0;
      mem_ack      <= 1'b0;
      mem_err      <= 1'b0;
      inst         <= '0;
      mem_data_out <= '0;

      case (state)
        IDLE: begin
          if (accept_c) begin
            state      <= grant_data_c ? BUSY_DATA : BUSY_INST;
            last_grant <= grant_data_c ? GRANT_DATA : GRANT_INST;
            cnt        <= CNT_W'(1);
            cur_write  <= grant_data_c & mem_write_en;
            cur_err    <= acc_oob_c;
            cur_idx    <= ram_idx_c;
          end
        end
        BUSY_INST, BUSY_DATA: begin
          if (inst_ack || mem_ack) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (complete_c) begin
        if (done_is_data_c) begin
          mem_ack      <= 1'b1;
          mem_err      <= done_err_c;
          mem_data_out <= (done_write_c || done_err_c) ? '0 : ram_rdata_c;
        end else begin
          inst_ack <= 1'b1;
          inst     <= done_err_c ? '0 : ram_rdata_c;
        end
      end
    end
  end

  arm_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we      (ram_we_c),
    .addr    (ram_idx_c),
    .wdata   (mem_data_in),
    .rdata_c (ram_rdata_c)
  );

endmodule

// File: tb/tb_arm_mem_responder.sv
// Self-checking bench: two responders (LATENCY 2 and 1) driven by directed and
// randomized traffic, checked against a word-level memory model and grant rules.
module tb_arm_mem_responder;

  localparam int unsigned NDUT = 2;
  localparam int unsigned DL2  = 12;
  localparam int unsigned LAT0 = 2;
  localparam int unsigned LAT1 = 1;
  localparam int unsigned WIN  = 64;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0]       rst;
  logic [NDUT-1:0]       inst_req;
  logic [NDUT-1:0][31:0] inst_addr;
  logic [NDUT-1:0][31:0] inst;
  logic [NDUT-1:0]       inst_ack;
  logic [NDUT-1:0]       mem_req;
  logic [NDUT-1:0]       mem_write_en;
  logic [NDUT-1:0][31:0] mem_addr;
  logic [NDUT-1:0][31:0] mem_data_in;
  logic [NDUT-1:0][31:0] mem_data_out;
  logic [NDUT-1:0]       mem_ack;
  logic [NDUT-1:0]       mem_err;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    arm_mem_responder #(
      .DEPTH_LOG2(DL2),
      .LATENCY   ((g == 0) ? LAT0 : LAT1)
    ) dut (
      .clk          (clk),
      .rst          (rst[g]),
      .inst_req     (inst_req[g]),
      .inst_addr    (inst_addr[g]),
      .inst         (inst[g]),
      .inst_ack     (inst_ack[g]),
      .mem_req      (mem_req[g]),
      .mem_write_en (mem_write_en[g]),
      .mem_addr     (mem_addr[g]),
      .mem_data_in  (mem_data_in[g]),
      .mem_data_out (mem_data_out[g]),
      .mem_ack      (mem_ack[g]),
      .mem_err      (mem_err[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: word contents of the test window and the last granted port.
  logic [31:0] model_mem [NDUT][WIN];
  bit          model_last_data [NDUT];

  op_t iq[$];
  op_t dq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
    return a >= 32'h0000_4000;
  endfunction

  function automatic logic [31:0] rand_addr(input bit oob);
    logic [31:0] a;
    if (oob) a = $urandom | (32'h1 << $urandom_range(14, 31));
    else     a = {24'h0, 6'($urandom_range(0, WIN - 1)), 2'($urandom_range(0, 3))};
    return a;
  endfunction

  task automatic drive_req(input int k, input bit is_data, input op_t op);
    if (is_data) begin
      mem_req[k]      = 1'b1;
      mem_write_en[k] = op.wr;
      mem_addr[k]     = op.addr;
      mem_data_in[k]  = op.data;
    end else begin
      inst_req[k]  = 1'b1;
      inst_addr[k] = op.addr;
    end
  endtask

  task automatic quiet(input int k);
    inst_req[k]     = 1'b0;
    mem_req[k]      = 1'b0;
    mem_write_en[k] = 1'b0;
  endtask

  task automatic check_idle_outputs(input int k, input string tag);
    check({tag, " acks"}, 32'({inst_ack[k], mem_ack[k], mem_err[k]}), 32'h0);
    check({tag, " inst"}, inst[k], 32'h0);
    check({tag, " mem_data_out"}, mem_data_out[k], 32'h0);
  endtask

  task automatic apply_reset(input int k, input string tag);
    rst[k] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs(k, tag);
    model_last_data[k] = 1'b1;
    rst[k] = 1'b0;
  endtask

  // One access: present, expect ack exactly LATENCY edges after acceptance.
  task automatic run_one(input int k, input bit is_data, input op_t op, input bit drop,
                         input string tag);
    int          lat;
    bit          oob;
    logic [31:0] exp_d;
    lat   = lat_of(k);
    oob   = is_oob(op.addr);
    exp_d = (oob || (is_data && op.wr)) ? 32'h0 : model_mem[k][op.addr[7:2]];
    drive_req(k, is_data, op);
    for (int c = 0; c < lat; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        model_last_data[k] = is_data;
        if (is_data && op.wr && !oob) model_mem[k][op.addr[7:2]] = op.data;
        if (drop) begin
          if (is_data) begin
            mem_req[k]      = 1'b0;
            mem_write_en[k] = 1'($urandom_range(0, 1));
            mem_addr[k]     = $urandom;
            mem_data_in[k]  = $urandom;
          end else begin
            inst_req[k]  = 1'b0;
            inst_addr[k] = $urandom;
          end
        end
      end
      if (c < lat - 1) check({tag, " early ack"}, 32'({inst_ack[k], mem_ack[k]}), 32'h0);
    end
    if (is_data) begin
      check({tag, " mem_ack"}, 32'(mem_ack[k]), 32'h1);
      check({tag, " mem_err"}, 32'(mem_err[k]), 32'(oob));
      check({tag, " mem_data_out"}, mem_data_out[k], exp_d);
      check({tag, " inst_ack idle"}, 32'(inst_ack[k]), 32'h0);
      check({tag, " inst idle"}, inst[k], 32'h0);
      mem_req[k] = 1'b0;
    end else begin
      check({tag, " inst_ack"}, 32'(inst_ack[k]), 32'h1);
      check({tag, " inst"}, inst[k], exp_d);
      check({tag, " mem_ack idle"}, 32'({mem_ack[k], mem_err[k]}), 32'h0);
      check({tag, " mem_data_out idle"}, mem_data_out[k], 32'h0);
      inst_req[k] = 1'b0;
    end
  endtask

  task automatic post_ack(input int k, input string tag);
    @(posedge clk);
    #1;
    check({tag, " ack width"}, 32'({inst_ack[k], mem_ack[k]}), 32'h0);
  endtask

  // Both ports keep requesting from queues iq/dq; grant follows the tie rule.
  task automatic contention(input int k, input bit from_reset, input string tag);
    bit  pick_data;
    op_t op;
    int  n;
    if (iq.size() != 0) drive_req(k, 1'b0, iq[0]);
    if (dq.size() != 0) drive_req(k, 1'b1, dq[0]);
    if (from_reset) apply_reset(k, {tag, " reset"});
    n = 0;
    while ((iq.size() != 0) || (dq.size() != 0)) begin
      if ((iq.size() != 0) && (dq.size() != 0)) pick_data = !model_last_data[k];
      else                                       pick_data = (dq.size() != 0);
      op = pick_data ? dq.pop_front() : iq.pop_front();
      run_one(k, pick_data, op, 1'b0, $sformatf("%s #%0d %s", tag, n, pick_data ? "D" : "I"));
      if (pick_data && (dq.size() != 0)) drive_req(k, 1'b1, dq[0]);
      if (!pick_data && (iq.size() != 0)) drive_req(k, 1'b0, iq[0]);
      post_ack(k, tag);
      n++;
    end
  endtask

  initial begin
    op_t         op;
    bit          is_data;
    bit          drop;
    string       t;
    logic [31:0] sv;

    rst          = '1;
    inst_req     = '0;
    mem_req      = '0;
    mem_write_en = '0;
    inst_addr    = '0;
    mem_addr     = '0;
    mem_data_in  = '0;

    for (int k = 0; k < int'(NDUT); k++) begin
      t = $sformatf("d%0d", k);
      quiet(k);
      apply_reset(k, {t, " reset"});

      // Preload the test window
      for (int i = 0; i < int'(WIN); i++) begin
        op = '{wr: 1'b1, addr: 32'(i * 4), data: $urandom};
        run_one(k, 1'b1, op, 1'b0, {t, " preload"});
        post_ack(k, t);
      end

      // Store then load at 0x10
      op = '{wr: 1'b1, addr: 32'h10, data: 32'hDEAD_BEEF};
      run_one(k, 1'b1, op, 1'b0, {t, " st 0x10"});
      post_ack(k, t);
      op = '{wr: 1'b0, addr: 32'h10, data: 32'h0};
      run_one(k, 1'b1, op, 1'b0, {t, " ld 0x10"});
      post_ack(k, t);

      // Out-of-range load/store do not touch index 0
      op = '{wr: 1'b1, addr: 32'h0, data: 32'h1234_5678};
      run_one(k, 1'b1, op, 1'b0, {t, " st 0x0"});
      post_ack(k, t);
      op = '{wr: 1'b0, addr: 32'h0001_0000, data: 32'h0};
      run_one(k, 1'b1, op, 1'b0, {t, " ld oob"});
      post_ack(k, t);
      op = '{wr: 1'b1, addr: 32'h0001_0000, data: 32'hFFFF_FFFF};
      run_one(k, 1'b1, op, 1'b0, {t, " st oob"});
      post_ack(k, t);
      op = '{wr: 1'b0, addr: 32'h0, data: 32'h0};
      run_one(k, 1'b1, op, 1'b0, {t, " ld 0x0 after oob"});
      post_ack(k, t);

      // Fetch whose request drops right after acceptance
      op = '{wr: 1'b0, addr: 32'h8, data: 32'h0};
      run_one(k, 1'b0, op, 1'b1, {t, " fetch drop"});
      post_ack(k, t);

      // Reset one cycle after a load acceptance
      if (lat_of(k) >= 2) begin
        sv = $urandom;
        op = '{wr: 1'b1, addr: 32'h20, data: sv};
        run_one(k, 1'b1, op, 1'b0, {t, " st before rst"});
        post_ack(k, t);
        op = '{wr: 1'b0, addr: 32'h20, data: 32'h0};
        drive_req(k, 1'b1, op);
        @(posedge clk);
        #1;
        check({t, " rst-mid no early ack"}, 32'({inst_ack[k], mem_ack[k]}), 32'h0);
        rst[k] = 1'b1;
        quiet(k);
        @(posedge clk);
        #1;
        check_idle_outputs(k, {t, " rst-mid"});
        rst[k] = 1'b0;
        model_last_data[k] = 1'b1;
        for (int c = 0; c < lat_of(k) + 2; c++) begin
          @(posedge clk);
          #1;
          check({t, " rst-mid discarded"}, 32'({inst_ack[k], mem_ack[k]}), 32'h0);
        end
        run_one(k, 1'b1, op, 1'b0, {t, " ld after rst"});
        check({t, " ld after rst value"}, sv, model_mem[k][8]);
        post_ack(k, t);
      end

      // Both ports requesting from reset release
      iq.delete();
      dq.delete();
      for (int i = 0; i < 4; i++) begin
        iq.push_back('{wr: 1'b0, addr: rand_addr(1'b0), data: 32'h0});
        dq.push_back('{wr: 1'b0, addr: rand_addr(1'b0), data: 32'h0});
      end
      contention(k, 1'b1, {t, " tie"});

      // Randomized single accesses
      for (int i = 0; i < 150; i++) begin
        is_data = 1'($urandom_range(0, 1));
        op.wr   = is_data && ($urandom_range(0, 1) == 1);
        op.addr = rand_addr($urandom_range(0, 7) == 0);
        op.data = $urandom;
        drop    = ($urandom_range(0, 3) == 0);
        run_one(k, is_data, op, drop, $sformatf("%s rnd%0d", t, i));
        post_ack(k, t);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
          check({t, " rnd gap"}, 32'({inst_ack[k], mem_ack[k]}), 32'h0);
        end
      end

      // Randomized continuous traffic on both ports
      iq.delete();
      dq.delete();
      for (int i = 0; i < 20; i++) begin
        iq.push_back('{wr: 1'b0, addr: rand_addr($urandom_range(0, 9) == 0), data: 32'h0});
        dq.push_back('{wr: ($urandom_range(0, 1) == 1), addr: rand_addr($urandom_range(0, 7) == 0),
                       data: $urandom});
      end
      for (int i = 0; i < 6; i++) dq.push_back('{wr: 1'b0, addr: rand_addr(1'b0), data: 32'h0});
      contention(k, 1'b0, {t, " mix"});

      // Continuous loads of freshly written words
      for (int i = 0; i < 3; i++) begin
        op = '{wr: 1'b1, addr: 32'(i * 4), data: $urandom};
        run_one(k, 1'b1, op, 1'b0, {t, " pre3"});
        post_ack(k, t);
      end
      iq.delete();
      dq.delete();
      for (int i = 0; i < 3; i++) dq.push_back('{wr: 1'b0, addr: 32'(i * 4), data: 32'h0});
      contention(k, 1'b0, {t, " stream"});

      quiet(k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
